// File: rtl/m68k_uart_pkg.sv
// Shared definitions for the m68k_uart peripheral: register offsets, STATUS bit
// positions, the minimum accepted DIV value and the serial FSM state type.
package m68k_uart_pkg;

  // Register offsets, selected by address[2:1]
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegDiv    = 2'd2;

  // STATUS bit positions
  localparam int unsigned BitRxNe    = 0;
  localparam int unsigned BitTxFull  = 1;
  localparam int unsigned BitTxIdle  = 2;
  localparam int unsigned BitRxOvr   = 3;
  localparam int unsigned BitFrmErr  = 4;
  localparam int unsigned BitTxOvf   = 5;
  localparam int unsigned BitRxCount = 8;  // 5-bit field [12:8]

  // Smallest bit period the divisor register accepts
  localparam logic [15:0] DivMin = 16'd16;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} ser_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead read data.
// Ports: clk/resetn (sync, active-low); push + wr_data write; pop advances the
// head; rd_data is the current head; full/empty/count report occupancy.
// Push and pop together are legal on a full FIFO (both serviced) and on an
// empty FIFO (push accepted, pop ignored).
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/m68k_uart.sv
// Memory-mapped 8N1 UART on the j68 16-bit bus.
// Ports: clk, resetn (sync, active-low); bus side sel/rd_ena/wr_ena/byte_ena/
// address/wr_data in, rd_data (registered) and data_ack out; serial side
// uart_rx (asynchronous) in, uart_tx (idle high) out.
// Registers: DATA (TX push / RX pop), STATUS (sticky flags, W1C), DIV.
module m68k_uart
  import m68k_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        rd_ena,
  input  logic        wr_ena,
  input  logic [1:0]  byte_ena,
  input  logic [3:0]  address,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        data_ack,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] ResetDiv = 16'(CLK_HZ / BAUD);

  logic [1:0]  reg_sel;
  logic        bus_wr, bus_rd, rd_start, rd_prev_q, rd_ack_q;
  logic [15:0] div_q, div_new, status, rd_val;
  logic        rx_ovr_q, frm_err_q, tx_ovf_q, w1c_en;
  logic        unused_addr;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty, rx_frm;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;

  ser_state_e  tx_state_q, rx_state_q;
  logic [15:0] tx_div_q, tx_cnt_q, rx_div_q, rx_cnt_q;
  logic [2:0]  tx_bit_q, rx_bit_q;
  logic [7:0]  tx_shift_q, rx_shift_q;
  logic        tx_q, tx_tick, rx_tick;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;

  assign unused_addr = ^{address[3], address[0]};
  assign reg_sel     = address[2:1];
  assign bus_wr      = sel & wr_ena;
  assign bus_rd      = sel & rd_ena;
  // Only the first cycle of a held read has side effects
  assign rd_start    = bus_rd & ~rd_prev_q;
  assign data_ack    = bus_wr | rd_ack_q;

  assign tx_push = bus_wr & (reg_sel == RegData) & byte_ena[0];
  assign rx_pop  = rd_start & (reg_sel == RegData) & ~rx_empty;
  assign w1c_en  = bus_wr & (reg_sel == RegStatus) & byte_ena[0];
  assign div_new = {byte_ena[1] ? wr_data[15:8] : div_q[15:8],
                    byte_ena[0] ? wr_data[7:0]  : div_q[7:0]};

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(tx_push), .wr_data(wr_data[7:0]), .pop(tx_pop),
    .rd_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push), .wr_data(rx_shift_q), .pop(rx_pop),
    .rd_data(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    status               = '0;
    status[BitRxNe]      = ~rx_empty;
    status[BitTxFull]    = tx_full;
    status[BitTxIdle]    = (tx_count == '0) && (tx_state_q == StIdle);
    status[BitRxOvr]     = rx_ovr_q;
    status[BitFrmErr]    = frm_err_q;
    status[BitTxOvf]     = tx_ovf_q;
    status[BitRxCount +: 5] = 5'(rx_count);
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      RegData:   rd_val = rx_empty ? 16'h0000 : {8'h00, rx_head};
      RegStatus: rd_val = status;
      RegDiv:    rd_val = div_q;
      default:   rd_val = '0;
    endcase
  end

  // Bus registers, divisor and sticky flags; a same-cycle set beats its W1C
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_prev_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data   <= '0;
      div_q     <= ResetDiv;
      rx_ovr_q  <= 1'b0;
      frm_err_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
    end else begin
      rd_prev_q <= bus_rd;
      rd_ack_q  <= bus_rd;
      if (rd_start) rd_data <= rd_val;
      if (bus_wr && (reg_sel == RegDiv) && (div_new >= DivMin)) div_q <= div_new;
      tx_ovf_q  <= (tx_ovf_q & ~(w1c_en & wr_data[BitTxOvf])) | (tx_push & tx_full & ~tx_pop);
      rx_ovr_q  <= (rx_ovr_q & ~(w1c_en & wr_data[BitRxOvr])) | (rx_push & rx_full & ~rx_pop);
      frm_err_q <= (frm_err_q & ~(w1c_en & wr_data[BitFrmErr])) | rx_frm;
    end
  end

  // Transmitter: a pop always means a new frame begins with the START bit
  assign uart_tx = tx_q;
  assign tx_tick = (tx_cnt_q == '0);
  assign tx_pop  = ~tx_empty & ((tx_state_q == StIdle) | ((tx_state_q == StStop) & tx_tick));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state_q <= StIdle;
      tx_q       <= 1'b1;
      tx_cnt_q   <= '0;
      tx_div_q   <= ResetDiv;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else if (tx_pop) begin
      tx_state_q <= StStart;
      tx_q       <= 1'b0;
      tx_div_q   <= div_q;
      tx_cnt_q   <= div_q - 16'd1;
      tx_bit_q   <= '0;
      tx_shift_q <= tx_head;
    end else if (tx_state_q != StIdle) begin
      if (!tx_tick) begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end else begin
        tx_cnt_q <= tx_div_q - 16'd1;
        case (tx_state_q)
          StStart: begin
            tx_state_q <= StData;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
          StData: begin
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= StStop;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
          default: tx_state_q <= StIdle;
        endcase
      end
    end
  end

  // Receiver: samples land mid-bit, DIV/2 after the start edge and DIV apart
  assign rx_tick = (rx_cnt_q == '0);
  assign rx_push = (rx_state_q == StStop) & rx_tick & rx_sync_q;
  assign rx_frm  = (rx_state_q == StStop) & rx_tick & ~rx_sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= ResetDiv;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (rx_state_q == StIdle) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_q <= StStart;
          rx_div_q   <= div_q;
          rx_cnt_q   <= (div_q >> 1) - 16'd1;
          rx_bit_q   <= '0;
        end
      end else if (!rx_tick) begin
        rx_cnt_q <= rx_cnt_q - 16'd1;
      end else begin
        rx_cnt_q <= rx_div_q - 16'd1;
        case (rx_state_q)
          StStart: rx_state_q <= rx_sync_q ? StIdle : StData;  // high start = glitch
          StData: begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= StStop;
          end
          default: rx_state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m68k_uart.sv
// Self-checking bench for m68k_uart: random bytes on both serial directions,
// compared against a queue-based model of the register map and FIFOs.
module tb_m68k_uart;

  localparam int unsigned Depth = 16;

  logic        clk_50mhz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        sel = 1'b0, rd_ena = 1'b0, wr_ena = 1'b0;
  logic [1:0]  byte_ena = 2'b00;
  logic [3:0]  address  = 4'h0;
  logic [15:0] wr_data  = 16'h0;
  logic [15:0] rd_data;
  logic        data_ack;
  logic        uart_rx  = 1'b1;
  logic        uart_tx;

  always #10 clk_50mhz = ~clk_50mhz;

  m68k_uart #(.CLK_HZ(50000000), .BAUD(115200), .FIFO_DEPTH(Depth)) dut (
    .clk(clk_50mhz), .resetn(rst_n), .sel(sel), .rd_ena(rd_ena), .wr_ena(wr_ena),
    .byte_ena(byte_ena), .address(address), .wr_data(wr_data), .rd_data(rd_data),
    .data_ack(data_ack), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Model of the peripheral as seen from the bus
  logic [7:0] rx_model[$];
  logic [7:0] tx_exp[$];
  logic [7:0] tx_got[$];
  bit         m_ovr = 0, m_frm = 0, m_txovf = 0;
  int         m_div = 434;

  logic [15:0] rd;
  logic [7:0]  b;
  int          lows;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_status(input bit tx_idle, input bit tx_full);
    logic [15:0] s;
    s       = '0;
    s[0]    = rx_model.size() != 0;
    s[1]    = tx_full;
    s[2]    = tx_idle;
    s[3]    = m_ovr;
    s[4]    = m_frm;
    s[5]    = m_txovf;
    s[12:8] = 5'(rx_model.size());
    return s;
  endfunction

  task automatic bus_write(input logic [1:0] off, input logic [15:0] data, input logic [1:0] be);
    @(negedge clk_50mhz);
    sel = 1'b1; wr_ena = 1'b1; wr_data = data; byte_ena = be;
    address = {1'($urandom_range(0, 1)), off, 1'($urandom_range(0, 1))};
    #1 check_eq("wr_ack", data_ack, 1);
    @(posedge clk_50mhz); #1;
    sel = 1'b0; wr_ena = 1'b0; byte_ena = 2'b00;
  endtask

  task automatic bus_read(input logic [1:0] off, input int hold, output logic [15:0] data);
    @(negedge clk_50mhz);
    sel = 1'b1; rd_ena = 1'b1;
    address = {1'($urandom_range(0, 1)), off, 1'($urandom_range(0, 1))};
    #1 check_eq("rd_ack_early", data_ack, 0);
    @(posedge clk_50mhz); #1;
    check_eq("rd_ack", data_ack, 1);
    data = rd_data;
    repeat (hold - 1) @(posedge clk_50mhz);
    #1;
    sel = 1'b0; rd_ena = 1'b0;
    @(posedge clk_50mhz);
  endtask

  // Drive one 8N1 frame at m_div cycles per bit and update the model
  task automatic uart_send(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50mhz);
      uart_rx = frame[i];
      repeat (m_div - 1) @(negedge clk_50mhz);
    end
    @(negedge clk_50mhz);
    uart_rx = 1'b1;
    if (!stop_bit) m_frm = 1;
    else if (rx_model.size() < Depth) rx_model.push_back(data);
    else m_ovr = 1;
  endtask

  // Decode one frame from uart_tx by mid-bit sampling
  task automatic tx_capture(output logic [7:0] data, output bit ok);
    int waited;
    waited = 0; ok = 0; data = '0;
    while (uart_tx !== 1'b0 && waited < 40 * m_div) begin
      @(posedge clk_50mhz); #1;
      waited++;
    end
    if (uart_tx !== 1'b0) return;
    repeat (m_div / 2) @(posedge clk_50mhz);
    #1;
    if (uart_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (m_div) @(posedge clk_50mhz);
      #1 data[i] = uart_tx;
    end
    repeat (m_div) @(posedge clk_50mhz);
    #1;
    if (uart_tx !== 1'b1) return;
    ok = 1;
  endtask

  initial begin
    // Reset
    repeat (4) @(posedge clk_50mhz);
    #1;
    check_eq("rst_uart_tx", uart_tx, 1);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_data_ack", data_ack, 0);
    @(negedge clk_50mhz) rst_n = 1'b1;
    bus_read(2'd1, 1, rd); check_eq("rst_status", rd, 16'h0004);
    bus_read(2'd2, 1, rd); check_eq("rst_div", rd, 434);
    bus_read(2'd3, 1, rd); check_eq("reg3_read", rd, 0);

    // Divisor: values below 16 are ignored
    bus_write(2'd2, 16'd8, 2'b11);
    bus_read(2'd2, 1, rd); check_eq("div_small_ignored", rd, 434);
    bus_write(2'd2, 16'd16, 2'b11);
    m_div = 16;
    bus_read(2'd2, 1, rd); check_eq("div_16", rd, 16);
    bus_write(2'd3, 16'hFFFF, 2'b11);
    bus_read(2'd3, 1, rd); check_eq("reg3_write_ignored", rd, 0);

    // Exact TX waveform for 0x55: low 2 cycles after the write cycle
    bus_write(2'd0, 16'h0055, 2'b01);
    check_eq("tx_before_start", uart_tx, 1);
    @(posedge clk_50mhz); #1;
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'h55, 1'b0};
      for (int t = 0; t < 160; t++) begin
        check_eq($sformatf("tx55_bit%0d", t / 16), uart_tx, fr[t / 16]);
        @(posedge clk_50mhz); #1;
      end
    end
    bus_read(2'd1, 1, rd); check_eq("tx_idle_after_frame", rd, model_status(1, 0));

    // TX overflow: a primer byte goes straight to the serialiser, so the FIFO
    // absorbs the next 16 burst bytes and the 17th is dropped
    fork
      begin
        logic [7:0] v;
        v = 8'($urandom);
        tx_exp.push_back(v);
        bus_write(2'd0, {8'h00, v}, 2'b01);
        for (int k = 0; k < 17; k++) begin
          v = 8'($urandom);
          if (k < Depth) tx_exp.push_back(v);
          else m_txovf = 1;
          bus_write(2'd0, {8'($urandom), v}, 2'b01);
        end
        bus_read(2'd1, 1, rd); check_eq("tx_ovf_status", rd, model_status(0, 1));
        bus_write(2'd1, 16'h0020, 2'b01);
        m_txovf = 0;
        bus_read(2'd1, 1, rd); check_eq("tx_ovf_w1c", rd, model_status(0, 1));
      end
      begin
        logic [7:0] cb;
        bit ok;
        for (int k = 0; k < 17; k++) begin
          tx_capture(cb, ok);
          check_eq($sformatf("tx_frame%0d_ok", k), ok, 1);
          if (!ok) break;
          tx_got.push_back(cb);
        end
      end
    join
    check_eq("tx_frame_count", tx_got.size(), tx_exp.size());
    for (int k = 0; k < tx_got.size() && k < tx_exp.size(); k++)
      check_eq($sformatf("tx_byte%0d", k), tx_got[k], tx_exp[k]);
    lows = 0;
    repeat (20 * m_div) begin
      @(posedge clk_50mhz); #1;
      if (uart_tx !== 1'b1) lows++;
    end
    check_eq("tx_no_extra_frame", lows, 0);
    bus_read(2'd1, 1, rd); check_eq("tx_drained", rd, model_status(1, 0));

    // RX single byte
    uart_send(8'hA3, 1'b1);
    bus_read(2'd1, 1, rd); check_eq("rx_status_one", rd, model_status(1, 0));
    bus_read(2'd0, 1, rd); check_eq("rx_data_a3", rd, {8'h00, rx_model.pop_front()});
    bus_read(2'd1, 1, rd); check_eq("rx_status_empty", rd, model_status(1, 0));
    bus_read(2'd0, 1, rd); check_eq("rx_read_empty", rd, 0);

    // Held read pops only once
    uart_send(8'($urandom), 1'b1);
    uart_send(8'($urandom), 1'b1);
    bus_read(2'd0, 2, rd); check_eq("rx_held_data", rd, {8'h00, rx_model.pop_front()});
    bus_read(2'd1, 1, rd); check_eq("rx_held_status", rd, model_status(1, 0));
    bus_read(2'd0, 1, rd); check_eq("rx_held_second", rd, {8'h00, rx_model.pop_front()});

    // Overrun: 17 bytes with nobody reading
    for (int k = 0; k < 17; k++) uart_send(8'($urandom), 1'b1);
    bus_read(2'd1, 1, rd); check_eq("rx_ovr_status", rd, model_status(1, 0));
    while (rx_model.size() != 0) begin
      bus_read(2'd0, 1, rd); check_eq("rx_ovr_data", rd, {8'h00, rx_model.pop_front()});
    end
    bus_read(2'd1, 1, rd); check_eq("rx_ovr_sticky", rd, model_status(1, 0));
    bus_write(2'd1, 16'h0008, 2'b01);
    m_ovr = 0;
    bus_read(2'd1, 1, rd); check_eq("rx_ovr_w1c", rd, model_status(1, 0));

    // Framing error
    uart_send(8'($urandom), 1'b0);
    bus_read(2'd1, 1, rd); check_eq("rx_frm_status", rd, model_status(1, 0));
    bus_write(2'd1, 16'h0010, 2'b01);
    m_frm = 0;
    bus_read(2'd1, 1, rd); check_eq("rx_frm_w1c", rd, model_status(1, 0));

    // Short glitch on the line
    @(negedge clk_50mhz) uart_rx = 1'b0;
    repeat (4) @(negedge clk_50mhz);
    uart_rx = 1'b1;
    repeat (60) @(posedge clk_50mhz);
    bus_read(2'd1, 1, rd); check_eq("rx_glitch", rd, model_status(1, 0));

    // Random mix of receive, read and clear operations
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 4))
        0, 1: uart_send(8'($urandom), ($urandom_range(0, 7) != 0));
        2: begin
          bus_read(2'd0, 1, rd);
          check_eq("rand_data", rd, rx_model.size() ? {8'h00, rx_model.pop_front()} : 16'h0);
        end
        3: begin
          bus_read(2'd1, 1, rd); check_eq("rand_status", rd, model_status(1, 0));
        end
        default: begin
          logic [15:0] m;
          m = 16'($urandom);
          bus_write(2'd1, m, 2'b01);
          if (m[3]) m_ovr = 0;
          if (m[4]) m_frm = 0;
          if (m[5]) m_txovf = 0;
        end
      endcase
    end
    bus_read(2'd1, 1, rd); check_eq("rand_final_status", rd, model_status(1, 0));

    // Reset during TX data bit 3, with a second byte still queued
    b = 8'($urandom);
    bus_write(2'd0, {8'h00, b}, 2'b01);
    bus_write(2'd0, 16'h00FF, 2'b01);
    repeat (68) @(posedge clk_50mhz);
    #1 check_eq("tx_bit3_before_rst", uart_tx, b[3]);
    @(negedge clk_50mhz) rst_n = 1'b0;
    @(posedge clk_50mhz); #1;
    check_eq("tx_rst_high", uart_tx, 1);
    @(negedge clk_50mhz) rst_n = 1'b1;
    rx_model.delete();
    m_ovr = 0; m_frm = 0; m_txovf = 0; m_div = 434;
    bus_read(2'd1, 1, rd); check_eq("post_rst_status", rd, 16'h0004);
    bus_read(2'd2, 1, rd); check_eq("post_rst_div", rd, 434);
    lows = 0;
    repeat (400) begin
      @(posedge clk_50mhz); #1;
      if (uart_tx !== 1'b1) lows++;
    end
    check_eq("post_rst_tx_quiet", lows, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
